// File: rtl/trng_dist.sv
// TRNG word-stream distributor: finds the SYNC0/SYNC1 header and queues the next valid word into one of CHANNELS show-ahead FIFOs.
// Optional build macro TRNG_DIST_EMPTY_FIRST_EN: when defined, the lowest-index empty channel wins over the round-robin scan.
module trng_dist #(
  parameter int                DATA_W   = 32,
  parameter int                CHANNELS = 4,
  parameter int                DEPTH    = 8,
  parameter logic [DATA_W-1:0] SYNC0    = 32'h00000071,
  parameter logic [DATA_W-1:0] SYNC1    = 32'h0280F76B,
  parameter int                DROP_W   = 16
) (
  input  logic                                   clk_sample,
  input  logic                                   rst,
  input  logic [DATA_W-1:0]                      data_i,
  input  logic                                   data_valid_i,
  input  logic [CHANNELS-1:0]                    rd,
  output logic [CHANNELS-1:0]                    ready,
  output logic [CHANNELS*DATA_W-1:0]             data_o,
  output logic [CHANNELS*$clog2(DEPTH+1)-1:0]    level,
  output logic [DROP_W-1:0]                      drop_cnt
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {S_WAIT, S_HUNT, S_CAPT} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       rr_q, rr_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic [PW-1:0]       wr_ptr_q [CHANNELS];
  logic [PW-1:0]       rd_ptr_q [CHANNELS];
  logic [LW-1:0]       level_q  [CHANNELS];
  logic [DATA_W-1:0]   mem_q    [CHANNELS][DEPTH];

  logic                capture;
  logic                found;
  logic [CW-1:0]       sel;
  int                  cand;
  logic [CHANNELS-1:0] full, empty, push, pop;

  always_comb begin
    full  = '0;
    empty = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      full[c]  = (level_q[c] == LW'(DEPTH));
      empty[c] = (level_q[c] == '0);
    end
  end

  // Scan runs backwards so the last hit is the first non-full channel from rr.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = 0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      cand = (int'(rr_q) + i) % CHANNELS;
      if (!full[cand]) begin
        found = 1'b1;
        sel   = CW'(cand);
      end
    end
`ifdef TRNG_DIST_EMPTY_FIRST_EN
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (empty[c]) begin
        found = 1'b1;
        sel   = CW'(c);
      end
    end
`endif
  end

  always_comb begin
    capture = data_valid_i && (state_q == S_CAPT);
    push    = '0;
    pop     = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      push[c] = capture && found && (sel == CW'(c));
      pop[c]  = rd[c] && !empty[c];
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    drop_d  = drop_q;
    if (data_valid_i) begin
      case (state_q)
        S_WAIT:  if (data_i == SYNC0) state_d = S_HUNT;
        S_HUNT:  if (data_i == SYNC1) state_d = S_CAPT;
        S_CAPT:  state_d = S_WAIT;
        default: state_d = S_WAIT;
      endcase
    end
    if (capture && found) begin
      rr_d = (sel == CW'(CHANNELS - 1)) ? '0 : sel + 1'b1;
    end
    if (capture && !found && (drop_q != '1)) begin
      drop_d = drop_q + 1'b1;
    end
  end

  always_ff @(posedge clk_sample) begin
    if (rst) begin
      state_q <= S_WAIT;
      rr_q    <= '0;
      drop_q  <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        level_q[c]  <= '0;
      end
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      drop_q  <= drop_d;
      for (int c = 0; c < CHANNELS; c++) begin
        if (push[c]) wr_ptr_q[c] <= wr_ptr_q[c] + 1'b1;
        if (pop[c])  rd_ptr_q[c] <= rd_ptr_q[c] + 1'b1;
        if (push[c] && !pop[c])      level_q[c] <= level_q[c] + 1'b1;
        else if (!push[c] && pop[c]) level_q[c] <= level_q[c] - 1'b1;
      end
    end
  end

  // Storage is deliberately left unreset; data_o is masked by ready instead.
  always_ff @(posedge clk_sample) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (push[c]) mem_q[c][wr_ptr_q[c]] <= data_i;
    end
  end

  always_comb begin
    ready  = '0;
    data_o = '0;
    level  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      ready[c]                    = !empty[c];
      data_o[c*DATA_W +: DATA_W]  = empty[c] ? '0 : mem_q[c][rd_ptr_q[c]];
      level[c*LW +: LW]           = level_q[c];
    end
  end

  assign drop_cnt = drop_q;

endmodule

// File: doc/trng_dist.md
# trng_dist

Parametrised single-clock successor to the TRNG sample buffer. It parses the raw TRNG word stream for the two-word sync header 0x00000071 followed by 0x0280F76B and captures the next valid word as the payload. The payload goes into one of CHANNELS independent show-ahead FIFOs, and each FIFO is drained by its own sampling consumer through a ready/rd handshake. Channel selection is round-robin, skips full channels, and optionally gives priority to empty channels. Payloads that arrive while all channels are full are dropped and counted.

## Interface
- DATA_W, 32, payload and sync word width
- CHANNELS, 4, number of consumer channels (1..16)
- DEPTH, 8, words per channel FIFO; power of two, at least 2
- SYNC0, 32'h00000071, first header word
- SYNC1, 32'h0280F76B, second header word
- DROP_W, 16, drop counter width

Ports:
- clk_sample  in  1  sole clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- data_i  in  DATA_W  TRNG word
- data_valid_i  in  1  data_i valid this cycle
- rd  in  CHANNELS  per-channel pop request
- ready  out  CHANNELS  channel non-empty
- data_o  out  CHANNELS*DATA_W  head word of channel c at [c*DATA_W +: DATA_W]
- level  out  CHANNELS*$clog2(DEPTH+1)  per-channel occupancy
- drop_cnt  out  DROP_W  saturating count of dropped payloads

## Operation
- Parser FSM, with transitions evaluated only on cycles where data_valid_i=1:
  - WAIT: data_i==SYNC0 -> HUNT; otherwise stay in WAIT.
  - HUNT: data_i==SYNC1 -> CAPT; any other word stays in HUNT.
  - CAPT: the word is the payload; write it to the selected channel; -> WAIT. A payload equal to SYNC0 is still data; the FSM does not re-arm on it.
- Channel selection, done in the CAPT cycle using the registered level values:
  - Default: the first channel with level<DEPTH, scanning rr, rr+1, … mod CHANNELS.
  - After a write to channel k, rr <= (k+1) mod CHANNELS. rr does not change on a drop.
- All channels full: the payload is discarded and drop_cnt increments, saturating at all-ones.
- FIFO per channel:
  - Circular write and read pointers, each log2(DEPTH) bits, wrapping naturally.
  - level counter ranges 0..DEPTH.
  - ready[c] = (level[c]!=0).
  - data_o slice c = storage[rd_ptr] when ready[c]=1, and all zeros when ready[c]=0.
- rd[c] while ready[c]=0 is ignored: no pointer or level change.
- Same-cycle write and pop on one channel: both take effect and level is unchanged.
- A channel at level==DEPTH is not selectable even if it is being popped in the same cycle.
- Sync-header words are never stored.

## Timing
- Reset (rst=1 at an edge): FSM=WAIT, rr=0, all pointers and levels 0, drop_cnt=0, ready=0, data_o=0, level=0. Storage contents are not reset.
- Reset asserted mid-frame or mid-drain discards the partial header and all queued words.
- Payload accepted at edge N: ready and level for that channel update after edge N, and the word is on data_o in the same cycle ready rises.
- Pop at edge N: the next head word (or zeros) is presented after edge N.
- Minimum frame is 3 valid cycles; with back-to-back frames the sustained write rate is 1 payload per 3 valid cycles.
- There is no combinational path from data_i or data_valid_i to any output. rd affects outputs only through registers.

## Configuration
- TRNG_DIST_EMPTY_FIRST_EN defined:
  - In CAPT, if any channel has level==0, the lowest-index empty channel is selected, overriding the rr scan.
  - rr still updates to k+1.
- Not defined: pure round-robin skip-full selection as above.

## Test plan
- Reset, then data_valid_i=1 with 0x71, 0x0280F76B, 0xDEADBEEF -> ready=0001, data_o[31:0]=0xDEADBEEF, level[0]=1, one cycle after the payload edge.
- Four frames with payloads 1,2,3,4 and no rd -> each channel holds one word: ch0=1, ch1=2, ch2=3, ch3=4; rr=0.
- 0x71, 0x55, 0x71, 0x0280F76B, 0x99 -> stray words are tolerated in HUNT and 0x99 is stored; a 0x0280F76B arriving in WAIT without a preceding 0x71 stores nothing.
- 33 frames with no rd (CHANNELS=4, DEPTH=8) -> every level=8, drop_cnt=1. Then rd[2] for one cycle plus one more frame -> that payload is stored in ch2 and drop_cnt stays 1.
- Ch0 at level 1 while a payload targets ch0 and rd[0]=1 in the same cycle -> level[0] stays 1 and data_o[31:0] shows the new word next cycle.
- With TRNG_DIST_EMPTY_FIRST_EN: preload ch0=2, ch1=0, ch2=1, ch3=0 words with rr=2, then one frame -> ch1 is written. Without the macro -> ch2 is written.
